uart_rx: RTL

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/uart_rx.sv
// UART receiver, 8N1, LSB first. Oversamples the synchronized line with a
// bit-period counter and samples each bit once at its middle.
module uart_rx #(
    parameter int BAUDRATE = 115200,
    parameter int FREQ     = 50_000_000
) (
    input  logic       CLK,
    input  logic       RESET_n,
    input  logic       RX,
    input  logic       RX_ACK,
    output logic [7:0] DATA_OUT,
    output logic       RX_RDY,
    output logic       OVERRUN,
    output logic       FRAME_ERR,
    output logic       BUSY
);

    localparam int T  = FREQ / BAUDRATE;
    localparam int CW = (T > 2) ? $clog2(T) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(T - 1);
    localparam logic [CW-1:0] CNT_MID  = CW'(T / 2 - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt_clk;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          rx_meta;
    logic          rx_s;
    logic          rx_d;
    logic          mid_bit;

    // Synchronizer plus one delay stage for falling-edge detection.
    // All flops reset high so a released reset never looks like a start edge.
    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_d    <= 1'b1;
        end else begin
            rx_meta <= RX;
            rx_s    <= rx_meta;
            rx_d    <= rx_s;
        end
    end

    assign mid_bit = (cnt_clk == CNT_MID);

    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            state     <= S_IDLE;
            cnt_clk   <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            DATA_OUT  <= 8'h00;
            RX_RDY    <= 1'b0;
            OVERRUN   <= 1'b0;
            FRAME_ERR <= 1'b0;
            BUSY      <= 1'b0;
        end else begin
            FRAME_ERR <= 1'b0;

            if (RX_ACK && RX_RDY) begin
                RX_RDY  <= 1'b0;
                OVERRUN <= 1'b0;
            end

            if (state != S_IDLE) begin
                cnt_clk <= (cnt_clk == CNT_LAST) ? '0 : cnt_clk + CW'(1);
            end

            case (state)
                S_IDLE: begin
                    if (!rx_s && rx_d) begin
                        state   <= S_START;
                        cnt_clk <= '0;
                        BUSY    <= 1'b1;
                    end
                end

                S_START: begin
                    if (mid_bit) begin
                        if (rx_s) begin
                            state <= S_IDLE;
                            BUSY  <= 1'b0;
                        end else begin
                            state   <= S_DATA;
                            bit_idx <= '0;
                        end
                    end
                end

                S_DATA: begin
                    if (mid_bit) begin
                        shreg <= {rx_s, shreg[7:1]};
                        if (bit_idx == 3'd7) begin
                            state <= S_STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end
                end

                S_STOP: begin
                    if (mid_bit) begin
                        if (rx_s) begin
                            // Leave at mid-stop so a back-to-back start edge is caught.
                            state <= S_IDLE;
                            BUSY  <= 1'b0;
                            if (!RX_RDY) begin
                                DATA_OUT <= shreg;
                                RX_RDY   <= 1'b1;
                            end else if (RX_ACK) begin
                                DATA_OUT <= shreg;
                                RX_RDY   <= 1'b1;
                                OVERRUN  <= 1'b0;
                            end else begin
                                OVERRUN <= 1'b1;
                            end
                        end else begin
                            FRAME_ERR <= 1'b1;
                            state     <= S_BREAK;
                        end
                    end
                end

                S_BREAK: begin
                    if (rx_s) begin
                        state <= S_IDLE;
                        BUSY  <= 1'b0;
                    end
                end

                default: begin
                    state <= S_IDLE;
                    BUSY  <= 1'b0;
                end
            endcase
        end
    end

endmodule
